// File: rtl/sr04_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sr04_echo_responder
//  Purpose  : HC-SR04 ultrasonic sensor emulator (responder side of the
//             trig/echo protocol). A valid trigger pulse is answered, after
//             a fixed burst delay, by an echo pulse whose width encodes the
//             distance latched at trigger acceptance (US_PER_CM us per cm).
//             Out-of-range distances return a TIMEOUT_US wide echo.
//  Ports    : clk         - system clock
//             rst         - synchronous reset, active-high
//             trig        - trigger from the measuring controller
//             distance_cm - distance to emulate, latched at trig acceptance
//             echo        - echo pulse back to the controller
//             busy        - high whenever the responder is not IDLE
//             meas_done   - 1-cycle pulse on the edge echo falls
//             trig_err    - 1-cycle pulse when trig was shorter than minimum
//             range_err   - level, latched distance was 0 or > MAX_CM
//  Revision : 1.0 - initial release
// ============================================================================
module sr04_echo_responder #(
    parameter int CLK_DIV     = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int DELAY_US    = 250,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [9:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       meas_done,
    output logic       trig_err,
    output logic       range_err
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       C_MIN_TRIG   = 8'(MIN_TRIG_US);
    localparam logic [15:0]      C_DELAY_LAST = 16'(DELAY_US - 1);
    localparam logic [15:0]      C_HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]      C_TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0]      C_US_PER_CM  = 16'(US_PER_CM);
    localparam logic [9:0]       C_MAX_CM     = 10'(MAX_CM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_DELAY   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t           r_state_q,     w_state_d;
    logic [DIV_W-1:0] r_div_q,       w_div_d;
    logic             r_trig_dly_q;
    logic [7:0]       r_wcnt_q,      w_wcnt_d;
    logic [15:0]      r_cnt_q,       w_cnt_d;
    logic [9:0]       r_cm_q,        w_cm_d;
    logic             r_echo_q,      w_echo_d;
    logic             r_busy_q,      w_busy_d;
    logic             r_meas_done_q, w_meas_done_d;
    logic             r_trig_err_q,  w_trig_err_d;
    logic             r_range_err_q, w_range_err_d;

    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_cm_bad;
    logic [15:0]      w_echo_n;

    // Free-running 1 us tick divider.
    assign w_tick  = (r_div_q == C_DIV_LAST);
    assign w_div_d = w_tick ? '0 : r_div_q + 1'b1;

    assign w_rise  =  trig & ~r_trig_dly_q;
    assign w_fall  = ~trig &  r_trig_dly_q;

    assign w_cm_bad = (distance_cm == 10'd0) || (distance_cm > C_MAX_CM);

    // Echo length in ticks; worst in-range case 1023*US_PER_CM fits 16 bits
    // for the intended parameter ranges.
    assign w_echo_n = r_range_err_q ? C_TIMEOUT : ({6'd0, r_cm_q} * C_US_PER_CM);

    // One counter serves DELAY, ECHO and HOLDOFF since these phases never
    // overlap; it is cleared on each phase entry.
    always_comb begin
        w_state_d     = r_state_q;
        w_wcnt_d      = r_wcnt_q;
        w_cnt_d       = r_cnt_q;
        w_cm_d        = r_cm_q;
        w_echo_d      = r_echo_q;
        w_meas_done_d = 1'b0;
        w_trig_err_d  = 1'b0;
        w_range_err_d = r_range_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_d = S_TRIG_HI;
                    // The rise edge itself is a clock on which trig is high,
                    // so a tick here is counted; this makes a pulse of exactly
                    // MIN_TRIG_US accepted independent of tick phase.
                    w_wcnt_d  = {7'd0, w_tick};
                end
            end
            S_TRIG_HI: begin
                if (w_fall) begin
                    if (r_wcnt_q >= C_MIN_TRIG) begin
                        w_state_d     = S_DELAY;
                        w_cm_d        = distance_cm;
                        w_range_err_d = w_cm_bad;
                        w_cnt_d       = 16'd0;
                    end else begin
                        w_state_d    = S_IDLE;
                        w_trig_err_d = 1'b1;
                    end
                end else if (w_tick && (r_wcnt_q != 8'hFF)) begin
                    w_wcnt_d = r_wcnt_q + 8'd1;
                end
            end
            S_DELAY: begin
                if (w_tick) begin
                    if (r_cnt_q == C_DELAY_LAST) begin
                        w_state_d = S_ECHO;
                        w_echo_d  = 1'b1;
                        w_cnt_d   = 16'd0;
                    end else begin
                        w_cnt_d = r_cnt_q + 16'd1;
                    end
                end
            end
            S_ECHO: begin
                if (w_tick) begin
                    if (r_cnt_q == (w_echo_n - 16'd1)) begin
                        w_state_d     = S_HOLDOFF;
                        w_echo_d      = 1'b0;
                        w_meas_done_d = 1'b1;
                        w_cnt_d       = 16'd0;
                    end else begin
                        w_cnt_d = r_cnt_q + 16'd1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (w_tick) begin
                    if (r_cnt_q == C_HOLD_LAST) begin
                        w_state_d = S_IDLE;
                        w_cnt_d   = 16'd0;
                    end else begin
                        w_cnt_d = r_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_echo_d  = 1'b0;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_div_q       <= '0;
            r_trig_dly_q  <= 1'b0;
            r_wcnt_q      <= 8'd0;
            r_cnt_q       <= 16'd0;
            r_cm_q        <= 10'd0;
            r_echo_q      <= 1'b0;
            r_busy_q      <= 1'b0;
            r_meas_done_q <= 1'b0;
            r_trig_err_q  <= 1'b0;
            r_range_err_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_div_q       <= w_div_d;
            r_trig_dly_q  <= trig;
            r_wcnt_q      <= w_wcnt_d;
            r_cnt_q       <= w_cnt_d;
            r_cm_q        <= w_cm_d;
            r_echo_q      <= w_echo_d;
            r_busy_q      <= w_busy_d;
            r_meas_done_q <= w_meas_done_d;
            r_trig_err_q  <= w_trig_err_d;
            r_range_err_q <= w_range_err_d;
        end
    end

    assign echo      = r_echo_q;
    assign busy      = r_busy_q;
    assign meas_done = r_meas_done_q;
    assign trig_err  = r_trig_err_q;
    assign range_err = r_range_err_q;

endmodule
`default_nettype wire
